// File: rtl/ram_hex_dumper.sv
// Reads an inclusive, wrapping address window from a synchronous RAM and streams
// each word to a UART as an ASCII hex line: optional "AAAA: " prefix, digits, CR LF.
module ram_hex_dumper #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int RAM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic              addr_en,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              uart_ready,
    output logic              uart_send,
    output logic [7:0]        uart_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    localparam int DATA_DIGS = DATA_W / 4;
    localparam int ADDR_DIGS = (ADDR_W + 3) / 4;
    localparam int ADDR_PAD  = ADDR_DIGS * 4;
    localparam int MAX_IDX   = (DATA_DIGS > ADDR_DIGS + 1) ? DATA_DIGS : ADDR_DIGS + 1;
    localparam int IDX_W     = $clog2(MAX_IDX + 1);
    localparam int LAT_W     = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_ADDR = 3'd3,
        S_DATA = 3'd4,
        S_CR   = 3'd5,
        S_LF   = 3'd6,
        S_NEXT = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0]  end_q, end_d;
    logic               aen_q, aen_d;
    logic               abort_pend_q, abort_pend_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               send_q, send_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;

    logic [ADDR_PAD-1:0] addr_sh;
    logic [DATA_W-1:0]   word_sh;
    logic                can_send;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // UART handshake: a byte is issued (uart_send=1 for one cycle, uart_data
    // updated in the same cycle) only when uart_ready=1 and no byte was issued
    // the cycle before; uart_data then holds until the next issue.
    assign can_send = uart_ready && !send_q;
    assign addr_sh  = ADDR_PAD'(cur_q) << {idx_q, 2'b00};
    assign word_sh  = word_q << {idx_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        end_d        = end_q;
        aen_d        = aen_q;
        abort_pend_d = abort_pend_q | abort;
        word_d       = word_q;
        idx_d        = idx_q;
        lat_d        = lat_q;
        send_d       = 1'b0;
        data_d       = data_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (start) begin
                    cur_d        = start_addr;
                    end_d        = end_addr;
                    aen_d        = addr_en;
                    abort_pend_d = abort;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_W'(RAM_LATENCY - 1)) begin
                    word_d  = ram_data;
                    idx_d   = '0;
                    state_d = aen_q ? S_ADDR : S_DATA;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ADDR: begin
                if (can_send) begin
                    send_d = 1'b1;
                    if (idx_q < IDX_W'(ADDR_DIGS)) begin
                        data_d = hex_char(addr_sh[ADDR_PAD-1 -: 4]);
                    end else if (idx_q == IDX_W'(ADDR_DIGS)) begin
                        data_d = 8'h3A;
                    end else begin
                        data_d = 8'h20;
                    end
                    if (idx_q == IDX_W'(ADDR_DIGS + 1)) begin
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (can_send) begin
                    send_d = 1'b1;
                    data_d = hex_char(word_sh[DATA_W-1 -: 4]);
                    if (idx_q == IDX_W'(DATA_DIGS - 1)) begin
                        state_d = S_CR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_CR: begin
                if (can_send) begin
                    send_d  = 1'b1;
                    data_d  = 8'h0D;
                    state_d = S_LF;
                end
            end
            S_LF: begin
                if (can_send) begin
                    send_d  = 1'b1;
                    data_d  = 8'h0A;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // abort_pend_q covers aborts seen up to the end of the line just sent.
                if (cur_q == end_q || abort_pend_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cur_d   = cur_q + 1'b1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            aen_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            word_q       <= '0;
            idx_q        <= '0;
            lat_q        <= '0;
            send_q       <= 1'b0;
            data_q       <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
            aen_q        <= aen_d;
            abort_pend_q <= abort_pend_d;
            word_q       <= word_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            send_q       <= send_d;
            data_q       <= data_d;
            done_q       <= done_d;
        end
    end

    assign ram_addr  = cur_q;
    assign ram_rd_en = (state_q == S_READ);
    assign uart_send = send_q;
    assign uart_data = data_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_hex_dumper.sv
// Directed bench for ram_hex_dumper: RAM model, byte/read monitor, one task per scenario.
module tb_ram_hex_dumper;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          addr_en;
    logic          abort;
    logic [AW-1:0] ram_addr;
    logic          ram_rd_en;
    logic [DW-1:0] ram_data = '0;
    logic          uart_ready;
    logic          uart_send;
    logic [7:0]    uart_data;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    ram_hex_dumper #(.DATA_W(DW), .ADDR_W(AW), .RAM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .addr_en(addr_en), .abort(abort),
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
        .uart_ready(uart_ready), .uart_send(uart_send), .uart_data(uart_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_rd_en) ram_data <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]    got_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] rd_q[$];
    int            cyc = 0;
    int            last_send_cyc;
    int            min_gap;
    int            done_cnt;
    bit            stable_err;
    bit            done_busy_err;
    logic [7:0]    last_data;

    always @(negedge clk) begin
        cyc++;
        if (uart_send) begin
            got_q.push_back(uart_data);
            if (last_send_cyc >= 0 && cyc - last_send_cyc < min_gap) min_gap = cyc - last_send_cyc;
            last_send_cyc = cyc;
            last_data     = uart_data;
        end else if (uart_data !== last_data) begin
            stable_err = 1'b1;
        end
        if (ram_rd_en) rd_q.push_back(ram_addr);
        if (done) begin
            done_cnt++;
            if (busy) done_busy_err = 1'b1;
        end
    end

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        rd_q.delete();
        done_cnt      = 0;
        min_gap       = 1000;
        last_send_cyc = -1;
        stable_err    = 1'b0;
        done_busy_err = 1'b0;
        last_data     = uart_data;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_line(input string s);
        push_str(s);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e,
                            input logic aen, input logic ab);
        @(negedge clk);
        start = 1'b1; start_addr = s; end_addr = e; addr_en = aen; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bytes(input int count, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (got_q.size() >= count) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks++; if (uart_send !== 1'b0) $display("FAIL reset_send got %b exp 0", uart_send); else n_pass++;
        n_checks++; if (uart_data !== 8'h00) $display("FAIL reset_data got %h exp 00", uart_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_checks++; if (ram_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", ram_rd_en); else n_pass++;
        n_checks++; if (ram_addr !== '0) $display("FAIL reset_addr got %0d exp 0", ram_addr); else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        mem[5] = 16'hA3F0;
        push_line("A3F0");
        do_start(6'd5, 6'd5, 1'b0, 1'b0);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL basic_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL basic_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL basic_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() != 1) $display("FAIL basic_reads got %0d exp 1", rd_q.size()); else n_pass++;
        if (rd_q.size() > 0) begin
            n_checks++; if (rd_q[0] !== 6'd5) $display("FAIL basic_rd_addr got %0d exp 5", rd_q[0]); else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL basic_done got %0d exp 1", done_cnt); else n_pass++;
        n_checks++; if (done_busy_err) $display("FAIL basic_done_busy got busy=1 exp busy=0 with done"); else n_pass++;
        n_checks++; if (min_gap < 2) $display("FAIL basic_gap got %0d exp >=2", min_gap); else n_pass++;
    endtask

    task automatic test_addr_prefix();
        bit ok;
        clear_mon();
        push_str("05: ");
        push_line("A3F0");
        do_start(6'd5, 6'd5, 1'b1, 1'b0);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL prefix_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL prefix_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL prefix_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [AW-1:0] exp_rd [4];
        exp_rd = '{6'd62, 6'd63, 6'd0, 6'd1};
        clear_mon();
        mem[62] = 16'h0001; mem[63] = 16'hFFFF; mem[0] = 16'h1234; mem[1] = 16'h00AB;
        push_line("0001"); push_line("FFFF"); push_line("1234"); push_line("00AB");
        do_start(6'd62, 6'd1, 1'b0, 1'b0);
        wait_done(500, ok);
        n_checks++; if (!ok) $display("FAIL wrap_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL wrap_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL wrap_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() != 4) $display("FAIL wrap_reads got %0d exp 4", rd_q.size()); else n_pass++;
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            n_checks++; if (rd_q[i] !== exp_rd[i]) $display("FAIL wrap_rd%0d got %0d exp %0d", i, rd_q[i], exp_rd[i]); else n_pass++;
        end
        n_checks++; if (done_cnt != 1) $display("FAIL wrap_done got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0;
        bit sent_in_stall;
        clear_mon();
        mem[9] = 16'h5C7E;
        push_line("5C7E");
        do_start(6'd9, 6'd9, 1'b0, 1'b0);
        wait_bytes(2, 200, ok);
        uart_ready = 1'b0;
        n_checks++; if (!ok) $display("FAIL bp_first_bytes got %0d exp 2", got_q.size()); else n_pass++;
        n0 = got_q.size();
        sent_in_stall = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (uart_send) sent_in_stall = 1'b1;
        end
        n_checks++; if (sent_in_stall) $display("FAIL bp_stall_send got send exp none"); else n_pass++;
        n_checks++; if (got_q.size() != n0) $display("FAIL bp_stall_count got %0d exp %0d", got_q.size(), n0); else n_pass++;
        n_checks++; if (uart_data !== 8'h43) $display("FAIL bp_held_data got %h exp 43", uart_data); else n_pass++;
        uart_ready = 1'b1;
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL bp_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL bp_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (min_gap < 2) $display("FAIL bp_gap got %0d exp >=2", min_gap); else n_pass++;
        n_checks++; if (stable_err) $display("FAIL bp_data_stable got change exp stable"); else n_pass++;
    endtask

    task automatic test_abort();
        bit ok;
        int n0;
        clear_mon();
        mem[0] = 16'h0F1E; mem[1] = 16'h2D3C; mem[2] = 16'h4B5A; mem[3] = 16'h6978;
        push_line("0F1E"); push_line("2D3C"); push_line("4B5A");
        do_start(6'd0, 6'd63, 1'b0, 1'b0);
        wait_bytes(14, 500, ok);
        n_checks++; if (!ok) $display("FAIL abort_reach got %0d exp 14", got_q.size()); else n_pass++;
        abort = 1'b1; start = 1'b1; start_addr = 6'd40; end_addr = 6'd40; addr_en = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL abort_timeout got no done exp done"); else n_pass++;
        repeat (20) @(negedge clk);
        n0 = got_q.size();
        n_checks++; if (n0 != exp_q.size()) $display("FAIL abort_len got %0d exp %0d", n0, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < n0; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL abort_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() != 3) $display("FAIL abort_reads got %0d exp 3", rd_q.size()); else n_pass++;
        n_checks++; if (done_cnt != 1) $display("FAIL abort_done got %0d exp 1", done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_start_abort_same();
        bit ok;
        clear_mon();
        mem[10] = 16'hBEEF; mem[11] = 16'h1111; mem[12] = 16'h2222;
        push_line("BEEF");
        do_start(6'd10, 6'd12, 1'b0, 1'b1);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL sa_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL sa_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL sa_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (rd_q.size() != 1) $display("FAIL sa_reads got %0d exp 1", rd_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit sent_after;
        clear_mon();
        mem[20] = 16'h7777;
        do_start(6'd20, 6'd25, 1'b1, 1'b0);
        wait_bytes(2, 200, ok);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (!ok) $display("FAIL rm_reach got %0d exp 2", got_q.size()); else n_pass++;
        n_checks++; if (uart_send !== 1'b0) $display("FAIL rm_send got %b exp 0", uart_send); else n_pass++;
        n_checks++; if (uart_data !== 8'h00) $display("FAIL rm_data got %h exp 00", uart_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (ram_rd_en !== 1'b0) $display("FAIL rm_rd_en got %b exp 0", ram_rd_en); else n_pass++;
        n_checks++; if (ram_addr !== '0) $display("FAIL rm_addr got %0d exp 0", ram_addr); else n_pass++;
        n_checks++; if (got_q.size() != 2) $display("FAIL rm_partial_len got %0d exp 2", got_q.size()); else n_pass++;
        if (got_q.size() >= 2) begin
            n_checks++; if (got_q[0] !== 8'h31 || got_q[1] !== 8'h34) $display("FAIL rm_partial got %h %h exp 31 34", got_q[0], got_q[1]); else n_pass++;
        end
        sent_after = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (uart_send || ram_rd_en || busy) sent_after = 1'b1;
        end
        n_checks++; if (sent_after) $display("FAIL rm_quiet got activity exp none"); else n_pass++;
        clear_mon();
        push_str("05: ");
        push_line("A3F0");
        do_start(6'd5, 6'd5, 1'b1, 1'b0);
        wait_done(200, ok);
        n_checks++; if (!ok) $display("FAIL rm_restart_timeout got no done exp done"); else n_pass++;
        n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rm_restart_len got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rm_restart_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0;
        addr_en = 1'b0; abort = 1'b0; uart_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_addr_prefix();
        test_wrap();
        test_backpressure();
        test_abort();
        test_start_abort_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_hex_dumper.md
Name: ram_hex_dumper

Overview:
- Parametrised successor to the fixed 16-bit/64-word RAM-to-UART dump path.
- On a start command, reads an inclusive address window from a synchronous RAM and prints each word as uppercase ASCII hex lines.
- Each line can carry an optional address prefix; a line is [ADDR ": "] DATA CR LF.
- Sits between the capture RAM read port and the UART transmitter; adds busy/done status and a graceful abort.

Parameters:
- DATA_W, 16, RAM word width; must be a multiple of 4; printed as DATA_W/4 hex digits.
- ADDR_W, 6, RAM address width; address printed as ceil(ADDR_W/4) hex digits, zero-padded at the MSB.
- RAM_LATENCY, 1, cycles from ram_rd_en to valid ram_data; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to start a dump; ignored while busy=1.
- start_addr  in  ADDR_W  first address; sampled on an accepted start.
- end_addr  in  ADDR_W  last address, inclusive; sampled on an accepted start.
- addr_en  in  1  1 = print the address prefix; sampled on an accepted start.
- abort  in  1  level; requests a stop after the current line.
- ram_addr  out  ADDR_W  RAM read address.
- ram_rd_en  out  1  single-cycle read strobe.
- ram_data  in  DATA_W  RAM read data.
- uart_ready  in  1  transmitter can accept a byte.
- uart_send  out  1  single-cycle byte strobe.
- uart_data  out  8  byte to transmit; valid while uart_send=1.
- busy  out  1  a dump is in progress.
- done  out  1  one-cycle pulse after the final LF is issued.

Behaviour:
- Reset values: ram_addr=0, ram_rd_en=0, uart_send=0, uart_data=8'h00, busy=0, done=0; FSM returns to IDLE. Reset takes effect on the next edge even mid-line; no partial bytes follow.
- FSM states:
  - IDLE: on start with busy=0, latch start_addr, end_addr and addr_en; set cur=start_addr and busy=1; go to READ.
  - READ: ram_addr=cur and ram_rd_en=1 for exactly one cycle; go to WAIT.
  - WAIT: count RAM_LATENCY cycles, then capture ram_data into the word register on the cycle it is valid; go to ADDR if addr_en, else DATA.
  - ADDR: send address digits MSB first, then 0x3A (':') and 0x20 (space).
  - DATA: send DATA_W/4 digits MSB first.
  - CR: send 0x0D.
  - LF: send 0x0A.
  - NEXT: if cur==end_addr or abort_pend, go to IDLE with busy=0 and a done pulse. Otherwise cur=cur+1 modulo 2^ADDR_W, go to READ.
- Hex encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46.
- UART handshake:
  - A byte is issued only when uart_ready=1 and uart_send was 0 in the previous cycle.
  - uart_send is high for exactly one cycle; uart_data is stable from that cycle until the next issue.
  - The cycle after a pulse is a mandatory gap; uart_ready is ignored in that cycle.
  - Back-to-back bytes are therefore at most one per 2 cycles.
  - uart_ready low stalls the FSM indefinitely, with no byte loss or duplication.
- Address window:
  - start_addr==end_addr: exactly one line.
  - end_addr<start_addr: the address wraps, e.g. ADDR_W=6, start=62, end=1 dumps 62,63,0,1.
  - start=0, end=2^ADDR_W-1: full RAM, 2^ADDR_W lines.
- Abort:
  - abort high in any non-IDLE cycle sets abort_pend; it clears on return to IDLE.
  - The current line always completes through LF; then done pulses.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start while busy is ignored.
  - start and abort in the same IDLE cycle: start is accepted and abort_pend is set, so exactly one line is printed.
  - reset overrides everything.
- ram_rd_en never asserts while a line is being transmitted; exactly one read per line.
- done and busy: done asserts in the same cycle busy falls; a new start is accepted from the following cycle.

Test Plan:
- Basic line (DATA_W=16, ADDR_W=6, uart_ready=1): ram[5]=16'hA3F0, start=5, end=5, addr_en=0 -> uart bytes 41 33 46 30 0D 0A, one ram_rd_en with ram_addr=5, then done.
- Address prefix: same RAM, addr_en=1 -> bytes 30 35 3A 20 41 33 46 30 0D 0A.
- Wrap: ram[62]=0001, ram[63]=FFFF, ram[0]=1234, ram[1]=00AB, start=62, end=1 -> four lines "0001","FFFF","1234","00AB" in order, ram_addr sequence 62,63,0,1, then done.
- Backpressure: hold uart_ready=0 for 20 cycles mid-DATA -> no uart_send, uart_data held; on release the stream resumes with no skipped or repeated byte; minimum send spacing is 2 cycles.
- Abort: full dump 0..63; pulse abort during line 3's second digit -> line 3 completes with 0D 0A, done pulses, no line 4 read; start pulsed while busy is ignored.
- Reset mid-op: assert reset during the address prefix -> next cycle all outputs at reset values, busy=0, no further bytes; a fresh start then works normally.
